// File: rtl/vx_dram_responder_if.sv
// DRAM request/response bundle between a cache DRAM port (master) and the
// memory responder (slave).
interface vx_dram_responder_if #(
  parameter int LINE_SIZE  = 64,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 28
);
  logic                     dram_req_valid;
  logic                     dram_req_rw;
  logic [LINE_SIZE-1:0]     dram_req_byteen;
  logic [ADDR_WIDTH-1:0]    dram_req_addr;
  logic [8*LINE_SIZE-1:0]   dram_req_data;
  logic [TAG_WIDTH-1:0]     dram_req_tag;
  logic                     dram_req_ready;
  logic                     dram_rsp_valid;
  logic [8*LINE_SIZE-1:0]   dram_rsp_data;
  logic [TAG_WIDTH-1:0]     dram_rsp_tag;
  logic                     dram_rsp_ready;

  modport master (
    output dram_req_valid, dram_req_rw, dram_req_byteen, dram_req_addr,
           dram_req_data, dram_req_tag, dram_rsp_ready,
    input  dram_req_ready, dram_rsp_valid, dram_rsp_data, dram_rsp_tag
  );

  modport slave (
    input  dram_req_valid, dram_req_rw, dram_req_byteen, dram_req_addr,
           dram_req_data, dram_req_tag, dram_rsp_ready,
    output dram_req_ready, dram_rsp_valid, dram_rsp_data, dram_rsp_tag
  );
endinterface

// File: rtl/vx_dram_responder.sv
// Line-wide DRAM responder: byte-enabled writes, fixed-latency tagged read
// responses through a credit-bounded in-order response queue.
module vx_dram_responder #(
  parameter int LINE_SIZE  = 64,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 28,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 4,
  parameter int RSPQ_SIZE  = 4
) (
  input  logic               clk,
  input  logic               reset,
  vx_dram_responder_if.slave dram_if
);
  localparam int DATA_W  = 8 * LINE_SIZE;
  localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PTR_W   = (RSPQ_SIZE > 1) ? $clog2(RSPQ_SIZE) : 1;
  localparam int CNT_W   = $clog2(RSPQ_SIZE + 1);
  localparam int ENTRY_W = DATA_W + TAG_WIDTH;

  typedef logic [ENTRY_W-1:0] entry_t;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [IDX_W-1:0]  req_idx;
  logic              req_fire, wr_fire, rd_fire;
  logic              push, pop, rsp_valid;
  entry_t            push_entry, head_entry;
  logic              unused_addr;

  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  q_cnt_q, q_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  entry_t            q_mem_q [RSPQ_SIZE];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSPQ_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Upper address bits only alias; keep them referenced for lint.
  assign unused_addr = ^dram_if.dram_req_addr;
  assign req_idx     = dram_if.dram_req_addr[IDX_W-1:0];

  assign dram_if.dram_req_ready = (outstanding_q < CNT_W'(RSPQ_SIZE));
  assign req_fire = dram_if.dram_req_valid && dram_if.dram_req_ready;
  assign wr_fire  = req_fire && dram_if.dram_req_rw;
  assign rd_fire  = req_fire && !dram_if.dram_req_rw;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < LINE_SIZE; b++) begin
        if (dram_if.dram_req_byteen[b]) begin
          mem_q[req_idx][b*8 +: 8] <= dram_if.dram_req_data[b*8 +: 8];
        end
      end
    end
  end

  // The line is captured at the accepting edge, so later writes cannot
  // disturb a read that is already in flight.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push       = rd_fire;
      assign push_entry = {mem_q[req_idx], dram_if.dram_req_tag};
    end else begin : g_pipe
      localparam int NSTG = LATENCY - 1;
      logic [NSTG-1:0] pipe_vld_q;
      entry_t          pipe_ent_q [NSTG];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pipe_vld_q <= '0;
        end else begin
          pipe_vld_q[0] <= rd_fire;
          for (int s = 1; s < NSTG; s++) begin
            pipe_vld_q[s] <= pipe_vld_q[s-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rd_fire) begin
          pipe_ent_q[0] <= {mem_q[req_idx], dram_if.dram_req_tag};
        end
        for (int s = 1; s < NSTG; s++) begin
          pipe_ent_q[s] <= pipe_ent_q[s-1];
        end
      end

      assign push       = pipe_vld_q[NSTG-1];
      assign push_entry = pipe_ent_q[NSTG-1];
    end
  endgenerate

  assign rsp_valid  = (q_cnt_q != '0);
  assign pop        = rsp_valid && dram_if.dram_rsp_ready;
  assign head_entry = q_mem_q[rd_ptr_q];

  assign dram_if.dram_rsp_valid = rsp_valid;
  assign dram_if.dram_rsp_data  = rsp_valid ? head_entry[ENTRY_W-1:TAG_WIDTH] : '0;
  assign dram_if.dram_rsp_tag   = rsp_valid ? head_entry[TAG_WIDTH-1:0] : '0;

  always_comb begin
    outstanding_d = outstanding_q;
    q_cnt_d       = q_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (rd_fire && !pop) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!rd_fire && pop) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end
    if (push && !pop) begin
      q_cnt_d = q_cnt_q + CNT_W'(1);
    end else if (!push && pop) begin
      q_cnt_d = q_cnt_q - CNT_W'(1);
    end
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding_q <= '0;
      q_cnt_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      q_cnt_q       <= q_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Queue storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem_q[wr_ptr_q] <= push_entry;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (q_cnt_q == CNT_W'(RSPQ_SIZE))));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(pop && !rd_fire && (outstanding_q == '0)));
  a_credit_bound: assert property (@(posedge clk) disable iff (!reset)
    outstanding_q <= CNT_W'(RSPQ_SIZE));
  a_rsp_has_read: assert property (@(posedge clk) disable iff (!reset)
    rsp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_vx_dram_responder.sv
// Directed bench for vx_dram_responder: requests push expected responses into
// a scoreboard that a negedge monitor drains and compares.
module tb_vx_dram_responder;
  localparam int LINE_SIZE  = 64;
  localparam int ADDR_WIDTH = 26;
  localparam int TAG_WIDTH  = 28;
  localparam int LATENCY    = 4;
  localparam int RSPQ_SIZE  = 4;
  localparam int DATA_W     = 8 * LINE_SIZE;

  typedef logic [DATA_W-1:0] line_t;
  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    line_t                data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vx_dram_responder_if #(.LINE_SIZE(LINE_SIZE), .ADDR_WIDTH(ADDR_WIDTH),
                         .TAG_WIDTH(TAG_WIDTH)) dram_if ();

  vx_dram_responder #(
    .LINE_SIZE(LINE_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .TAG_WIDTH(TAG_WIDTH),
    .MEM_DEPTH(1024), .LATENCY(LATENCY), .RSPQ_SIZE(RSPQ_SIZE)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .dram_if(dram_if)
  );

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input line_t act, input line_t req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic line_t pat(input logic [7:0] b);
    return {LINE_SIZE{b}};
  endfunction

  task automatic req(input logic rw, input logic [ADDR_WIDTH-1:0] addr,
                     input line_t data, input logic [LINE_SIZE-1:0] be,
                     input logic [TAG_WIDTH-1:0] tag, input line_t exp_data);
    int n;
    n = 0;
    dram_if.dram_req_valid  = 1'b1;
    dram_if.dram_req_rw     = rw;
    dram_if.dram_req_addr   = addr;
    dram_if.dram_req_data   = data;
    dram_if.dram_req_byteen = be;
    dram_if.dram_req_tag    = tag;
    while (!dram_if.dram_req_ready && n < 50) begin
      tick();
      n++;
    end
    tests++;
    if (!dram_if.dram_req_ready) begin
      fails++;
      $display("FAIL req_accept: tag %0h not accepted within %0d cycles", tag, n);
    end else begin
      if (!rw) exp_q.push_back({tag, exp_data});
      $display("[TB] %s addr=%0h tag=%0h accepted", rw ? "WR" : "RD", addr, tag);
      tick();
    end
    dram_if.dram_req_valid = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_WIDTH-1:0] addr, input line_t data,
                    input logic [LINE_SIZE-1:0] be);
    req(1'b1, addr, data, be, '0, '0);
  endtask

  task automatic rd(input logic [ADDR_WIDTH-1:0] addr,
                    input logic [TAG_WIDTH-1:0] tag, input line_t exp_data);
    req(1'b0, addr, '0, '0, tag, exp_data);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    dram_if.dram_rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses still missing", exp_q.size());
    end
    tick();
  endtask

  // Monitor: compares every popped response and checks outputs hold under stall.
  initial begin : monitor
    exp_t                 e;
    logic                 stall_q;
    logic [TAG_WIDTH-1:0] stall_tag;
    stall_q   = 1'b0;
    stall_tag = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          tests++;
          if (!dram_if.dram_rsp_valid || dram_if.dram_rsp_tag !== stall_tag) begin
            fails++;
            $display("FAIL rsp_hold: valid=%0b tag=%0h expected valid=1 tag=%0h",
                     dram_if.dram_rsp_valid, dram_if.dram_rsp_tag, stall_tag);
          end
        end
        stall_q   = dram_if.dram_rsp_valid && !dram_if.dram_rsp_ready;
        stall_tag = dram_if.dram_rsp_tag;
        if (dram_if.dram_rsp_valid && dram_if.dram_rsp_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rsp_unexpected: tag %0h with nothing outstanding",
                     dram_if.dram_rsp_tag);
          end else begin
            e = exp_q.pop_front();
            if (dram_if.dram_rsp_tag !== e.tag || dram_if.dram_rsp_data !== e.data) begin
              fails++;
              $display("FAIL rsp: tag %0h data %0h expected tag %0h data %0h",
                       dram_if.dram_rsp_tag, dram_if.dram_rsp_data, e.tag, e.data);
            end else begin
              $display("[TB] RSP tag=%0h ok", e.tag);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   lat;
    line_t be_exp;

    dram_if.dram_req_valid  = 1'b0;
    dram_if.dram_req_rw     = 1'b0;
    dram_if.dram_req_addr   = '0;
    dram_if.dram_req_data   = '0;
    dram_if.dram_req_byteen = '0;
    dram_if.dram_req_tag    = '0;
    dram_if.dram_rsp_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("reset_rsp_valid", dram_if.dram_rsp_valid, 1'b0);
    check("reset_rsp_data", dram_if.dram_rsp_data, '0);
    check("reset_rsp_tag", dram_if.dram_rsp_tag, '0);
    check("reset_req_ready", dram_if.dram_req_ready, 1'b1);

    // Write then read with latency measurement.
    wr(26'h10, pat(8'hA5), '1);
    rd(26'h10, 28'h3, pat(8'hA5));
    lat = 1;
    while (!dram_if.dram_rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("read_latency", line_t'(lat), line_t'(LATENCY));
    wait_drain();

    // Byte enables.
    wr(26'h20, '0, '1);
    wr(26'h20, '1, 64'hF);
    be_exp = '0;
    be_exp[31:0] = '1;
    rd(26'h20, 28'h7, be_exp);
    wait_drain();

    // Backpressure and credits.
    for (int i = 1; i <= 6; i++) wr(26'h100 + 26'(i), pat(8'h30 + 8'(i)), '1);
    dram_if.dram_rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) rd(26'h100 + 26'(i), 28'(i), pat(8'h30 + 8'(i)));
    check("credit_ready_drop", dram_if.dram_req_ready, 1'b0);
    fork
      begin
        rd(26'h105, 28'd5, pat(8'h35));
        rd(26'h106, 28'd6, pat(8'h36));
      end
      begin
        repeat (LATENCY + 2) tick();
        check("credit_stall_ready", dram_if.dram_req_ready, 1'b0);
        check("credit_stall_pending", line_t'(exp_q.size()), line_t'(4));
        dram_if.dram_rsp_ready = 1'b1;
        tick();
        check("credit_ready_after_pop", dram_if.dram_req_ready, 1'b1);
      end
    join
    wait_drain();

    // Simultaneous accept and pop at full credit.
    dram_if.dram_rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) rd(26'h100 + 26'(i), 28'h10 + 28'(i), pat(8'h30 + 8'(i)));
    repeat (LATENCY + 1) tick();
    dram_if.dram_rsp_ready = 1'b1;
    tick();
    rd(26'h105, 28'h15, pat(8'h35));
    dram_if.dram_rsp_ready = 1'b0;
    check("simul_ready_at3", dram_if.dram_req_ready, 1'b1);
    rd(26'h106, 28'h16, pat(8'h36));
    check("simul_full_at4", dram_if.dram_req_ready, 1'b0);
    wait_drain();

    // Read/write race on the same line.
    wr(26'h40, pat(8'h11), '1);
    rd(26'h40, 28'h21, pat(8'h11));
    wr(26'h40, pat(8'h22), '1);
    rd(26'h40, 28'h22, pat(8'h22));
    wait_drain();

    // Async reset with reads outstanding; memory must survive.
    wr(26'h80, pat(8'h5C), '1);
    dram_if.dram_rsp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) rd(26'h80, 28'h30 + 28'(i), pat(8'h5C));
    repeat (2) tick();
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", dram_if.dram_rsp_valid, 1'b0);
    check("async_rst_data", dram_if.dram_rsp_data, '0);
    check("async_rst_tag", dram_if.dram_rsp_tag, '0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_ready", dram_if.dram_req_ready, 1'b1);
    dram_if.dram_rsp_ready = 1'b1;
    repeat (LATENCY + 6) tick();
    check("post_rst_no_stale", dram_if.dram_rsp_valid, 1'b0);
    rd(26'h10, 28'h41, pat(8'hA5));
    rd(26'h80, 28'h42, pat(8'h5C));
    wait_drain();
    check("scoreboard_empty", line_t'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vx_dram_responder.md
Name: vx_dram_responder

Overview:
- DRAM-side responder for one cache DRAM port. It is the far end of the dram_req / dram_rsp handshake that the icache and dcache drive.
- Holds a line-wide memory array and applies byte-enabled writes.
- Returns read lines with their tag after a fixed latency, through a credit-bounded response queue.
- Used as the behavioural/FPGA-BRAM memory behind a core's caches in simulation and small configurations.

Parameters:
- LINE_SIZE, 64, line width in bytes; data width is 8*LINE_SIZE.
- ADDR_WIDTH, 26, width of the line address.
- TAG_WIDTH, 28, width of the request/response tag.
- MEM_DEPTH, 1024, number of lines stored; power of two, ≤ 2^ADDR_WIDTH.
- LATENCY, 4, accept-to-response cycles with no backpressure; must be ≥1.
- RSPQ_SIZE, 4, maximum outstanding reads (pipeline plus queue); must be ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- dram_req_valid  in  1  request valid.
- dram_req_rw  in  1  1 = write, 0 = read.
- dram_req_byteen  in  LINE_SIZE  write byte enables.
- dram_req_addr  in  ADDR_WIDTH  line address.
- dram_req_data  in  8*LINE_SIZE  write data.
- dram_req_tag  in  TAG_WIDTH  request tag.
- dram_req_ready  out  1  request accepted when valid && ready.
- dram_rsp_valid  out  1  read response valid.
- dram_rsp_data  out  8*LINE_SIZE  read line.
- dram_rsp_tag  out  TAG_WIDTH  tag of the originating read.
- dram_rsp_ready  in  1  consumer accepts the response when valid && ready.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values:
  - dram_rsp_valid=0, dram_rsp_data=0, dram_rsp_tag=0.
  - Outstanding counter=0, pipeline valid bits=0, queue pointers=0.
  - dram_req_ready=1 once reset deasserts.
  - The memory array is not reset; its contents persist across reset.
- Indexing: index = dram_req_addr[log2(MEM_DEPTH)-1:0]. Upper address bits are ignored, so addresses alias modulo MEM_DEPTH.
- Ready: dram_req_ready = (outstanding < RSPQ_SIZE). It is combinational from registered state only, never from dram_req_valid or dram_req_rw. It gates writes as well as reads.
- Write accept (valid && ready && rw):
  - At the accepting edge, byte b of the line is updated iff byteen[b].
  - No response is generated; outstanding is unchanged.
- Read accept (valid && ready && !rw):
  - The line is read at the accepting edge, so data reflects all writes accepted in earlier cycles.
  - A write accepted in a later cycle does not alter an in-flight read.
  - {data, tag} enter a LATENCY-1 stage valid-tracked shift pipeline, then the response queue. With LATENCY=1 the entry goes directly to the queue.
- Response timing: for a read accepted at edge t, with the queue empty and dram_rsp_ready=1, dram_rsp_valid is first high in the cycle after edge t+LATENCY-1 (LATENCY cycles after acceptance).
- Response queue:
  - FIFO of depth RSPQ_SIZE, registered outputs, strict in-order responses.
  - Pop on dram_rsp_valid && dram_rsp_ready.
  - While dram_rsp_ready=0, the valid/data/tag outputs hold stable.
- Outstanding counter:
  - +1 on read accept, −1 on response pop. Simultaneous accept and pop leaves it unchanged.
  - Never exceeds RSPQ_SIZE, so the queue can never overflow. Pipeline entries always find queue space because the credit limit bounds them.
- Overflow and underflow are never reached by construction; simulation assertions flag either, and also flag dram_rsp_valid without a matching outstanding read.
- Reset mid-operation: in-flight reads and queued responses are discarded, and outputs return to their reset values immediately (asynchronously).

Test Plan:
- Write then read, LATENCY=4: write addr=0x10, data all 0xA5, byteen all-ones. Next cycle read addr=0x10, tag=0x3. dram_rsp_valid rises exactly 4 cycles after read accept, data=all 0xA5, tag=0x3. No response for the write.
- Byte enables: line 0x20 holds all 0x00. Write data all 0xFF with byteen=0x...0F. Read returns bytes 0-3 = 0xFF and the rest 0x00.
- Backpressure and credits, RSPQ_SIZE=4, dram_rsp_ready=0: issue 6 back-to-back reads with tags 1..6. dram_req_ready drops after the 4th accept; tags 5 and 6 stall. Raise rsp_ready: responses come out in order 1,2,3,4,5,6, ready reasserts after the first pop, and no response is lost or duplicated.
- Simultaneous accept and pop at outstanding=4 with ready low: after popping one, accept a read in the same cycle as the next pop. Outstanding stays at 3 and ordering is preserved.
- Read/write race: read addr 0x40 accepted at cycle t, write 0x40 accepted at t+1 with new data. The response carries the old data; a read at t+2 returns the new data.
- Async reset: assert reset with 3 reads outstanding. dram_rsp_valid=0 immediately. After deassert, dram_req_ready=1, no stale responses appear, and the memory contents written before reset read back intact.
